// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane/state types, rate presets, squeeze FSM
// states and the lane-index to (x, y) mapping.
package keccak_pkg;

    localparam int unsigned N       = 64;
    localparam int unsigned STATE_W = 25 * N;

    typedef logic [N-1:0] lane_t;
    typedef lane_t [4:0]  plane_t;   // indexed by x
    typedef plane_t [4:0] state_t;   // indexed by y, so state[y][x][z]

    // Rate in lanes for the standard instances.
    localparam int unsigned RATE_SHA3_224  = 18;
    localparam int unsigned RATE_SHA3_256  = 17;
    localparam int unsigned RATE_SHA3_384  = 13;
    localparam int unsigned RATE_SHA3_512  = 9;
    localparam int unsigned RATE_SHAKE128  = 21;
    localparam int unsigned RATE_SHAKE256  = 17;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSt,
        StEmit,
        StReq,
        StDone
    } sqz_state_e;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_xy_t;

    // Standard lane numbering i = x + 5y.
    function automatic lane_xy_t lane_xy(input logic [4:0] idx);
        lane_xy_t r;
        r.x = 3'(idx % 5'd5);
        r.y = 3'(idx / 5'd5);
        return r;
    endfunction

endpackage

// File: rtl/keccak_lane_sel.sv
// Combinational lane picker: returns lane idx_i (i = x + 5y) of a 1600-bit
// state. Indices above 24 return zero. Shared with the absorb side.
module keccak_lane_sel
    import keccak_pkg::*;
(
    input  logic [STATE_W-1:0] st_i,
    input  logic [4:0]         idx_i,
    output logic [N-1:0]       lane_o
);

    state_t   st;
    lane_xy_t xy;

    assign st = st_i;
    assign xy = lane_xy(idx_i);

    // Mux the addressed lane; out-of-range indices read as zero.
    always_comb begin
        lane_o = '0;
        if (idx_i < 5'd25) begin
            lane_o = st[xy.y][xy.x];
        end
    end

endmodule

// File: rtl/keccak_squeeze.sv
// Keccak squeeze-side reader. Captures a permuted state, streams the rate
// lanes as registered valid/ready beats and requests further permutations
// until the requested number of lanes has been emitted.
// Optional build macro KECCAK_SQZ_ZEROIZE_EN: clears the state buffer on
// entry to DONE and drives dout_o to zero whenever dout_valid_o is low.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int unsigned RATE_LANES = 17,
    parameter int unsigned LEN_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   out_lanes_i,
    input  logic [STATE_W-1:0] st_i,
    input  logic               st_valid_i,
    output logic               st_ready_o,
    output logic               perm_req_o,
    output logic [N-1:0]       dout_o,
    output logic               dout_valid_o,
    input  logic               dout_ready_i,
    output logic               dout_last_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

    sqz_state_e         state_q, state_d;
    logic [STATE_W-1:0] buf_q, buf_d;
    logic [4:0]         lane_idx_q, lane_idx_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [N-1:0]       dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic [STATE_W-1:0] sel_st;
    logic [4:0]         sel_idx;
    logic [N-1:0]       sel_lane;

    // Lane feeding the next beat: lane 0 of the incoming state while
    // capturing, otherwise the lane after the current one in the buffer.
    always_comb begin
        if (state_q == StWaitSt) begin
            sel_st  = st_i;
            sel_idx = '0;
        end else begin
            sel_st  = buf_q;
            sel_idx = lane_idx_q + 5'd1;
        end
    end

    keccak_lane_sel u_lane_sel (
        .st_i   (sel_st),
        .idx_i  (sel_idx),
        .lane_o (sel_lane)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        lane_idx_d = lane_idx_q;
        rem_d      = rem_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        last_d     = last_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (out_lanes_i != '0) begin
                        rem_d   = out_lanes_i;
                        state_d = StWaitSt;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWaitSt: begin
                if (st_valid_i) begin
                    buf_d      = st_i;
                    lane_idx_d = '0;
                    dout_d     = sel_lane;
                    valid_d    = 1'b1;
                    last_d     = (rem_q == LEN_W'(1));
                    state_d    = StEmit;
                end
            end
            StEmit: begin
                if (dout_ready_i) begin
                    rem_d      = rem_q - LEN_W'(1);
                    lane_idx_d = lane_idx_q + 5'd1;
                    // Completion wins over a rate-block boundary.
                    if (rem_q == LEN_W'(1)) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = StDone;
                    end else if (lane_idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        dout_d = sel_lane;
                        last_d = (rem_q == LEN_W'(2));
                    end
                end
            end
            StReq: begin
                state_d = StWaitSt;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef KECCAK_SQZ_ZEROIZE_EN
        if (state_d == StDone && state_q != StDone) begin
            buf_d = '0;
        end
        if (!valid_d) begin
            dout_d = '0;
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            lane_idx_q <= '0;
            rem_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            lane_idx_q <= lane_idx_d;
            rem_q      <= rem_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign st_ready_o   = (state_q == StWaitSt);
    assign perm_req_o   = (state_q == StReq);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);

endmodule
